// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Scan state enum, nibble width and active-low OFF levels.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam int NIBBLE_W = 4;

  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON  = 1'b0;
  localparam logic DP_OFF    = 1'b1;
  localparam logic DP_ON     = 1'b0;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake bundle between display-value producer and scanner.
// master drives req/digits/dp/en, slave returns the ack pulse.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                         JM1222HM_load_req;
  logic [NIBBLE_W*NUM_DIGITS-1:0] JM1222HM_digits;
  logic [NUM_DIGITS-1:0]        JM1222HM_dp_in;
  logic [NUM_DIGITS-1:0]        JM1222HM_en_in;
  logic                         JM1222HM_load_ack;

  modport master (
    output JM1222HM_load_req,
    output JM1222HM_digits,
    output JM1222HM_dp_in,
    output JM1222HM_en_in,
    input  JM1222HM_load_ack
  );

  modport slave (
    input  JM1222HM_load_req,
    input  JM1222HM_digits,
    input  JM1222HM_dp_in,
    input  JM1222HM_en_in,
    output JM1222HM_load_ack
  );

endinterface

// File: rtl/seg_slot_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot.
// Ports: clk, rst, load/load_val, cnt, tc (cnt == 0).
module seg_slot_timer #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with frame-aligned shadow loading.
// Ports: clk, rst, load handshake (if), nibble, anode_n, dp_n, frame_start.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  JM1222HM_clk,
  input  logic                  JM1222HM_rst,
  seg_scan_ctrl_if.slave        JM1222HM_ld,
  output logic [NIBBLE_W-1:0]   JM1222HM_nibble,
  output logic [NUM_DIGITS-1:0] JM1222HM_anode_n,
  output logic                  JM1222HM_dp_n,
  output logic                  JM1222HM_frame_start
);

  localparam int CNT_MAX =
    (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LD  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_e state, n_state;
  logic [IW-1:0] idx, n_idx;
  logic [CW-1:0] cnt, ld_val;
  logic          tc;
  logic          boundary, capture, ack_q;

  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] sh_dig, n_dig;
  logic [NUM_DIGITS-1:0] sh_dp, sh_en, n_dp, n_en;

  // Down-counter reset value equals the first BLANK cycle's load,
  // so "cnt == BLANK_LD in BLANK" marks the first cycle of a slot.
  seg_slot_timer #(
    .W       (CW),
    .RST_VAL (BLANK_LD)
  ) u_timer (
    .clk      (JM1222HM_clk),
    .rst      (JM1222HM_rst),
    .load     (tc),
    .load_val (ld_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  assign ld_val   = (state == BLANK) ? SHOW_LD : BLANK_LD;
  assign boundary = (state == BLANK) && (idx == '0)
                 && (cnt == BLANK_LD);
  assign capture  = boundary & JM1222HM_ld.JM1222HM_load_req;

  assign n_dig = capture ? JM1222HM_ld.JM1222HM_digits : sh_dig;
  assign n_dp  = capture ? JM1222HM_ld.JM1222HM_dp_in  : sh_dp;
  assign n_en  = capture ? JM1222HM_ld.JM1222HM_en_in  : sh_en;

  assign JM1222HM_ld.JM1222HM_load_ack = ack_q;

  always_comb begin
    n_state = state;
    n_idx   = idx;
    if (tc) begin
      unique case (state)
        BLANK: n_state = SHOW;
        SHOW: begin
          n_state = BLANK;
          n_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        default: n_state = BLANK;
      endcase
    end
  end

  always_ff @(posedge JM1222HM_clk) begin
    if (JM1222HM_rst) begin
      state <= BLANK;
      idx   <= '0;
    end else begin
      state <= n_state;
      idx   <= n_idx;
    end
  end

  always_ff @(posedge JM1222HM_clk) begin
    if (JM1222HM_rst) begin
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_en  <= '0;
    end else begin
      sh_dig <= n_dig;
      sh_dp  <= n_dp;
      sh_en  <= n_en;
    end
  end

  // Outputs are registered from next-state values so they line up
  // with the state they describe, including a same-edge capture.
  always_ff @(posedge JM1222HM_clk) begin
    if (JM1222HM_rst) begin
      JM1222HM_anode_n     <= {NUM_DIGITS{ANODE_OFF}};
      JM1222HM_dp_n        <= DP_OFF;
      JM1222HM_nibble      <= '0;
      JM1222HM_frame_start <= 1'b0;
      ack_q                <= 1'b0;
    end else begin
      JM1222HM_nibble      <= n_dig[n_idx];
      JM1222HM_frame_start <= boundary;
      ack_q                <= capture;
      if (n_state == SHOW && n_en[n_idx]) begin
        JM1222HM_anode_n <= ~(NUM_DIGITS'(1) << n_idx);
      end else begin
        JM1222HM_anode_n <= {NUM_DIGITS{ANODE_OFF}};
      end
      if (n_state == SHOW && n_en[n_idx] && n_dp[n_idx]) begin
        JM1222HM_dp_n <= DP_ON;
      end else begin
        JM1222HM_dp_n <= DP_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl.
// NUM_DIGITS=4, SHOW=8, BLANK=2: slot 10 cycles, frame 40 cycles.
module tb_seg_scan_ctrl;

  localparam logic [10:0] RST_VEC = 11'b1111_1_0000_0_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) ld ();

  logic [3:0]  nibble;
  logic [3:0]  anode_n;
  logic        dp_n;
  logic        fs;
  logic [10:0] got;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SHOW_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .JM1222HM_clk         (clk),
    .JM1222HM_rst         (rst),
    .JM1222HM_ld          (ld),
    .JM1222HM_nibble      (nibble),
    .JM1222HM_anode_n     (anode_n),
    .JM1222HM_dp_n        (dp_n),
    .JM1222HM_frame_start (fs)
  );

  assign got = {anode_n, dp_n, nibble,
                ld.JM1222HM_load_ack, fs};

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] sh_dig  = '0;
  logic [3:0]  sh_dp   = '0;
  logic [3:0]  sh_en   = '0;
  logic        exp_ack = 1'b0;

  // One clock of the reference model; cyc counts from reset release.
  task automatic tick();
    logic        cap;
    logic [15:0] d;
    logic [3:0]  p, e;
    cap = (cyc % 40 == 0) && ld.JM1222HM_load_req;
    d = ld.JM1222HM_digits;
    p = ld.JM1222HM_dp_in;
    e = ld.JM1222HM_en_in;
    @(posedge clk);
    #1;
    cyc++;
    exp_ack = cap;
    if (cap) begin
      sh_dig = d;
      sh_dp  = p;
      sh_en  = e;
    end
  endtask

  function automatic logic [10:0] exp_vec();
    int pos, slot;
    logic show, dp;
    logic [3:0] an;
    pos  = cyc % 40;
    slot = pos / 10;
    show = (pos % 10) >= 2;
    an = (show && sh_en[slot]) ? ~(4'b0001 << slot) : 4'b1111;
    dp = !(show && sh_dp[slot] && sh_en[slot]);
    return {an, dp, sh_dig[slot*4 +: 4], exp_ack, (cyc % 40 == 1)};
  endfunction

  task automatic model_reset();
    cyc     = 0;
    sh_dig  = '0;
    sh_dp   = '0;
    sh_en   = '0;
    exp_ack = 1'b0;
  endtask

  task automatic test_reset();
    ld.JM1222HM_load_req = 1'b0;
    ld.JM1222HM_digits   = '0;
    ld.JM1222HM_dp_in    = '0;
    ld.JM1222HM_en_in    = '0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (got !== RST_VEC) begin
        errs++;
        $display("FAIL reset_hold got=%b exp=%b", got, RST_VEC);
      end
    end
    rst = 1'b0;
    model_reset();
    repeat (80) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL reset_scan cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
      if (cyc == 1 || cyc == 41) begin
        checks++;
        if (fs !== 1'b1) begin
          errs++;
          $display("FAIL frame_start cyc=%0d got=%b exp=1", cyc, fs);
        end
      end
    end
  endtask

  task automatic test_load_scan();
    logic [8:0] e;
    logic       chk;
    ld.JM1222HM_load_req = 1'b1;
    ld.JM1222HM_digits   = 16'h4321;
    ld.JM1222HM_en_in    = 4'hF;
    ld.JM1222HM_dp_in    = 4'h0;
    repeat (40) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL load_scan cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
      if (ld.JM1222HM_load_ack) ld.JM1222HM_load_req = 1'b0;
      chk = 1'b1;
      e   = '0;
      case (cyc % 40)
        1:  e = {1'b1, 4'b1111, 4'h1};
        5:  e = {1'b0, 4'b1110, 4'h1};
        11: e = {1'b0, 4'b1111, 4'h2};
        15: e = {1'b0, 4'b1101, 4'h2};
        25: e = {1'b0, 4'b1011, 4'h3};
        35: e = {1'b0, 4'b0111, 4'h4};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({ld.JM1222HM_load_ack, anode_n, nibble} !== e) begin
          errs++;
          $display("FAIL load_scan_dir cyc=%0d got=%b exp=%b", cyc,
                   {ld.JM1222HM_load_ack, anode_n, nibble}, e);
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [4:0] e;
    logic       chk;
    repeat (45) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL midframe cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
      if (cyc == 135) begin
        ld.JM1222HM_load_req = 1'b1;
        ld.JM1222HM_digits   = 16'h9999;
      end
      if (ld.JM1222HM_load_ack) ld.JM1222HM_load_req = 1'b0;
      chk = 1'b1;
      e   = '0;
      case (cyc)
        145: e = {1'b0, 4'h3};
        155: e = {1'b0, 4'h4};
        160: e = {1'b0, 4'h1};
        161: e = {1'b1, 4'h9};
        165: e = {1'b0, 4'h9};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({ld.JM1222HM_load_ack, nibble} !== e) begin
          errs++;
          $display("FAIL midframe_dir cyc=%0d got=%b exp=%b", cyc,
                   {ld.JM1222HM_load_ack, nibble}, e);
        end
      end
    end
  endtask

  task automatic test_enable_dp();
    logic [5:0] e;
    logic       chk;
    repeat (80) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL enable_dp cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
      if (cyc == 190) begin
        ld.JM1222HM_load_req = 1'b1;
        ld.JM1222HM_digits   = 16'h8765;
        ld.JM1222HM_en_in    = 4'b0101;
        ld.JM1222HM_dp_in    = 4'b0011;
      end
      if (ld.JM1222HM_load_ack) ld.JM1222HM_load_req = 1'b0;
      chk = 1'b1;
      e   = '0;
      case (cyc)
        205: e = {4'b1110, 1'b0, 1'b0};
        215: e = {4'b1111, 1'b1, 1'b0};
        225: e = {4'b1011, 1'b1, 1'b0};
        235: e = {4'b1111, 1'b1, 1'b0};
        241: e = {4'b1111, 1'b1, 1'b1};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({anode_n, dp_n, fs} !== e) begin
          errs++;
          $display("FAIL enable_dp_dir cyc=%0d got=%b exp=%b", cyc,
                   {anode_n, dp_n, fs}, e);
        end
      end
    end
  endtask

  task automatic test_pulse_and_hold();
    logic [4:0] e;
    logic       chk;
    int         acks;
    acks = 0;
    repeat (120) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL pulse_hold cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
      if (ld.JM1222HM_load_ack) acks++;
      if (cyc == 265) begin
        ld.JM1222HM_load_req = 1'b1;
        ld.JM1222HM_digits   = 16'hAAAA;
        ld.JM1222HM_en_in    = 4'hF;
        ld.JM1222HM_dp_in    = 4'h0;
      end
      if (cyc == 266) ld.JM1222HM_load_req = 1'b0;
      if (cyc == 285) begin
        ld.JM1222HM_load_req = 1'b1;
        ld.JM1222HM_digits   = 16'h1234;
      end
      if (cyc == 362) ld.JM1222HM_load_req = 1'b0;
      chk = 1'b1;
      e   = '0;
      case (cyc)
        281: e = {1'b0, 4'h5};
        321: e = {1'b1, 4'h4};
        361: e = {1'b1, 4'h4};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({ld.JM1222HM_load_ack, nibble} !== e) begin
          errs++;
          $display("FAIL pulse_hold_dir cyc=%0d got=%b exp=%b", cyc,
                   {ld.JM1222HM_load_ack, nibble}, e);
        end
      end
    end
    checks++;
    if (acks !== 2) begin
      errs++;
      $display("FAIL hold_ack_count got=%0d exp=2", acks);
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] e;
    logic       chk;
    repeat (20) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
    end
    checks++;
    if (anode_n !== 4'b1011) begin
      errs++;
      $display("FAIL pre_reset_anode got=%b exp=1011", anode_n);
    end
    ld.JM1222HM_load_req = 1'b1;
    ld.JM1222HM_digits   = 16'h5555;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (got !== RST_VEC) begin
      errs++;
      $display("FAIL mid_reset got=%b exp=%b", got, RST_VEC);
    end
    rst = 1'b0;
    model_reset();
    repeat (45) begin
      tick();
      checks++;
      if (got !== exp_vec()) begin
        errs++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b",
                 cyc, got, exp_vec());
      end
      if (ld.JM1222HM_load_ack) ld.JM1222HM_load_req = 1'b0;
      chk = 1'b1;
      e   = '0;
      case (cyc)
        1: e = {1'b1, 4'b1111, 4'h5};
        5: e = {1'b0, 4'b1110, 4'h5};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({ld.JM1222HM_load_ack, anode_n, nibble} !== e) begin
          errs++;
          $display("FAIL post_reset_dir cyc=%0d got=%b exp=%b", cyc,
                   {ld.JM1222HM_load_ack, anode_n, nibble}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_scan();
    test_midframe_load();
    test_enable_dp();
    test_pulse_and_hold();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler for the shared 4-bit to seven-segment decoder path on the calculator board. Sequences NUM_DIGITS display digits through one decoder, driving one active-low anode at a time with a blanking guard between digits. Holds a shadow copy of the display value, updated only at frame boundaries via a req/ack handshake, so the display never tears mid-frame.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SHOW_CYCLES, 50000, clock cycles each digit's anode is on (>=1)
BLANK_CYCLES, 500, clock cycles all anodes are off before each digit (>=1)

Ports:
JM1222HM_clk  in  1  system clock
JM1222HM_rst  in  1  synchronous reset, active-high
JM1222HM_load_req  in  1  level request to load new display value; hold until ack
JM1222HM_digits  in  4*NUM_DIGITS  digit nibbles; digit i = bits [4i+3:4i]; digit 0 is rightmost
JM1222HM_dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high
JM1222HM_en_in  in  NUM_DIGITS  per-digit enable; 0 = digit blank
JM1222HM_load_ack  out  1  one-cycle pulse: inputs captured into shadow
JM1222HM_nibble  out  4  current digit value, to segment decoder inputs
JM1222HM_anode_n  out  NUM_DIGITS  digit anodes, active-low
JM1222HM_dp_n  out  1  decimal point, active-low
JM1222HM_frame_start  out  1  one-cycle pulse at the start of digit 0's blank slot

Behaviour:
- Reset: the next edge with rst=1 sets anode_n all 1, dp_n=1, nibble=0, load_ack=0, frame_start=0, shadow digits/dp/en=0, digit index=0, state=BLANK, slot counter=0. Reset mid-frame aborts the scan; a pending request is not acked.
- FSM: BLANK -> SHOW after BLANK_CYCLES cycles. SHOW -> BLANK after SHOW_CYCLES cycles. On SHOW->BLANK, the index increments, wrapping NUM_DIGITS-1 -> 0. Slot = BLANK_CYCLES+SHOW_CYCLES cycles. Frame = NUM_DIGITS slots.
- All outputs are registered. In BLANK, anode_n is all 1 and dp_n=1. From the first BLANK cycle, nibble already shows shadow digit[index], giving the decoder the full blank period to settle.
- In SHOW: anode_n[index]=0 only if shadow en[index]=1, otherwise all 1. The disabled slot still consumes its time, so brightness stays uniform. dp_n = ~(shadow dp[index] & shadow en[index]).
- Frame boundary: the cycle with state=BLANK, index=0, counter=0. This includes the first cycle after reset release.
  - frame_start is 1 in the following cycle.
  - If load_req=1 on the boundary cycle, digits/dp_in/en_in are captured into the shadow at that edge, and load_ack=1 for exactly the following cycle.
  - load_req sampled at any other time has no effect.
  - If the requester drops load_req before the boundary, no capture and no ack.
  - If load_req stays high after ack, a new capture and ack occur at the next boundary. The requester must deassert on ack.
- Nibble for digit 0 after a capture reflects the new value from the cycle after the boundary. No digit of a frame mixes old and new values.
- Counter width: clog2(max(SHOW_CYCLES,BLANK_CYCLES)). Index width: clog2(NUM_DIGITS). The counter counts 0..N-1 and resets to 0 on each state change.

Decomposition:
- Shared package seg_pkg:
  - scan state enum (BLANK, SHOW)
  - NIBBLE_W=4
  - active-low anode/dp OFF constants
- One natural sub-module: seg_slot_timer (loadable down-counter with terminal-count pulse, parameterised width). The FSM, index, shadow registers and handshake stay in seg_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=4, SHOW_CYCLES=8, BLANK_CYCLES=2, so slot=10 cycles and frame=40 cycles.
1. Reset, then hold rst=1 for 3 cycles -> anode_n=4'b1111, dp_n=1, nibble=0, load_ack=0. After release, frame_start pulses 1 cycle later and again every 40 cycles.
2. load_req=1 held with digits=16'h4321, en=4'hF -> load_ack is a single pulse one cycle after the boundary. Per slot, nibble steps 1,2,3,4. anode_n follows 1110,1101,1011,0111 for 8 cycles each, separated by 2 cycles of 1111.
3. Raise load_req with digits=16'h9999 at frame cycle 15 -> no ack until the next boundary (cycle 40). Digits 2 and 3 of the current frame still show old values.
4. en=4'b0101, dp_in=4'b0011 -> anodes for digits 1 and 3 stay 1 during their SHOW. dp_n=0 only during digit 0's SHOW. Slot timing is unchanged (frame still 40 cycles).
5. Pulse load_req for 1 cycle not on a boundary -> no capture and no ack. Hold load_req through two boundaries -> two acks 40 cycles apart.
6. Assert rst during digit 2's SHOW -> all anodes off at the next edge, shadow=0. The scan restarts at digit 0 BLANK, and the pending request is not acked until the first post-reset boundary.
